// File: rtl/pos_frame_tx_pkg.sv
// Shared definitions for the position packetiser: field width, FSM state codes,
// and helpers for chunk counts, index widths and byte tags.
package pos_frame_tx_pkg;

    localparam int unsigned POS_FIELD_W = 12;

    typedef logic [1:0] pos_tx_state_t;

    localparam pos_tx_state_t PTX_IDLE = 2'd0;
    localparam pos_tx_state_t PTX_SEND = 2'd1;
    localparam pos_tx_state_t PTX_GAP  = 2'd2;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Width of an index that counts 0..n-1; at least one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    // Tag 0 is reserved so the receiver can spot a stray or idle byte.
    function automatic int unsigned pos_tag(input int unsigned c, input int unsigned k,
                                            input int unsigned n_chunk);
        return c * n_chunk + k + 1;
    endfunction

endpackage

// File: rtl/pos_frame_tx_chunk_mux.sv
// Selects one {payload, tag} byte out of the latched frame for channel ch_idx,
// chunk chunk_idx; the final chunk is zero-padded above POS_W.
module pos_frame_tx_chunk_mux
    import pos_frame_tx_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned POS_W   = 10,
    parameter int unsigned CHUNK_W = 5,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned N_CHUNK = ceil_div(POS_W, CHUNK_W),
    parameter int unsigned CH_IW   = idx_w(N_CH),
    parameter int unsigned CK_IW   = idx_w(N_CHUNK)
) (
    input  logic [N_CH*POS_W-1:0]     frame,
    input  logic [CH_IW-1:0]          ch_idx,
    input  logic [CK_IW-1:0]          chunk_idx,
    output logic [CHUNK_W+TAG_W-1:0]  tx_byte
);

    localparam int unsigned PAD_W = N_CHUNK * CHUNK_W;

    logic [PAD_W-1:0]   padded;
    logic [CHUNK_W-1:0] payload;
    logic [TAG_W-1:0]   tag;

    always_comb begin
        padded = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == CH_IW'(c)) begin
                padded[POS_W-1:0] = frame[c*POS_W +: POS_W];
            end
        end
    end

    always_comb begin
        payload = '0;
        for (int k = 0; k < N_CHUNK; k++) begin
            if (chunk_idx == CK_IW'(k)) begin
                payload = padded[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    assign tag     = TAG_W'(pos_tag(32'(ch_idx), 32'(chunk_idx), N_CHUNK));
    assign tx_byte = {payload, tag};

endmodule

// File: rtl/pos_frame_tx.sv
// Position packetiser: snapshots N_CH coordinates and writes tagged chunk bytes into
// the UART TX FIFO whenever a coordinate changes or the refresh period expires.
module pos_frame_tx
    import pos_frame_tx_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned POS_W       = 10,
    parameter int unsigned CHUNK_W     = 5,
    parameter int unsigned TAG_W       = 3,
    parameter int unsigned REFRESH_CYC = 0,
    parameter int unsigned GAP_CYC     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [POS_FIELD_W*N_CH-1:0] pos_in,
    input  logic                        tx_full,
    output logic                        wr_uart,
    output logic [7:0]                  w_data,
    output logic                        busy,
    output logic [15:0]                 frame_cnt
);

    localparam int unsigned N_CHUNK = ceil_div(POS_W, CHUNK_W);
    localparam int unsigned CH_IW   = idx_w(N_CH);
    localparam int unsigned CK_IW   = idx_w(N_CHUNK);
    localparam int unsigned REF_W   = idx_w(REFRESH_CYC);
    localparam int unsigned GAP_W   = idx_w(GAP_CYC);
    localparam int unsigned FRAME_W = N_CH * POS_W;
    localparam int unsigned REF_MAX = (REFRESH_CYC == 0) ? 0 : REFRESH_CYC - 1;
    localparam int unsigned GAP_MAX = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;

    if (CHUNK_W + TAG_W != 8) begin : g_bad_byte_w
        $error("pos_frame_tx: CHUNK_W + TAG_W must equal 8");
    end
    if (N_CH == 0 || POS_W == 0 || POS_W > POS_FIELD_W) begin : g_bad_pos_w
        $error("pos_frame_tx: need N_CH >= 1 and 1 <= POS_W <= POS_FIELD_W");
    end
    if (N_CH * N_CHUNK + 1 > (1 << TAG_W)) begin : g_bad_tag_w
        $error("pos_frame_tx: too many chunks for TAG_W");
    end

    pos_tx_state_t       state_q, state_d;
    logic [CH_IW-1:0]    ch_q, ch_d;
    logic [CK_IW-1:0]    ck_q, ck_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [FRAME_W-1:0]  snap_q, snap_d;
    logic [REF_W-1:0]    refresh_q, refresh_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                wr_q, wr_d;
    logic [7:0]          data_q, data_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [FRAME_W-1:0]  pos_now;
    logic [7:0]          tx_byte;
    logic                refresh_hit;
    logic                last_chunk;
    logic                last_byte;

    always_comb begin
        pos_now = '0;
        for (int c = 0; c < N_CH; c++) begin
            pos_now[c*POS_W +: POS_W] = pos_in[c*POS_FIELD_W +: POS_W];
        end
    end

    pos_frame_tx_chunk_mux #(
        .N_CH    (N_CH),
        .POS_W   (POS_W),
        .CHUNK_W (CHUNK_W),
        .TAG_W   (TAG_W),
        .N_CHUNK (N_CHUNK),
        .CH_IW   (CH_IW),
        .CK_IW   (CK_IW)
    ) u_chunk_mux (
        .frame     (frame_q),
        .ch_idx    (ch_q),
        .chunk_idx (ck_q),
        .tx_byte   (tx_byte)
    );

    assign refresh_hit = (REFRESH_CYC != 0) && (refresh_q == REF_W'(REF_MAX));
    assign last_chunk  = (ck_q == CK_IW'(N_CHUNK - 1));
    assign last_byte   = last_chunk && (ch_q == CH_IW'(N_CH - 1));

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        ck_d      = ck_q;
        frame_d   = frame_q;
        snap_d    = snap_q;
        refresh_d = refresh_q;
        gap_d     = gap_q;
        wr_d      = 1'b0;
        data_d    = data_q;
        cnt_d     = cnt_q;

        case (state_q)
            PTX_IDLE: begin
                if (!enable) begin
                    refresh_d = '0;
                end else if (pos_now != snap_q || refresh_hit) begin
                    frame_d   = pos_now;
                    ch_d      = '0;
                    ck_d      = '0;
                    refresh_d = '0;
                    state_d   = PTX_SEND;
                end else if (REFRESH_CYC != 0) begin
                    refresh_d = refresh_q + 1'b1;
                end
            end

            PTX_SEND: begin
                // The FIFO full flag needs a cycle to reflect each write, so
                // never issue in the cycle right after a strobe.
                if (!tx_full && !wr_q) begin
                    wr_d   = 1'b1;
                    data_d = tx_byte;
                    if (last_byte) begin
                        snap_d  = frame_q;
                        cnt_d   = cnt_q + 16'd1;
                        ch_d    = '0;
                        ck_d    = '0;
                        gap_d   = '0;
                        state_d = (GAP_CYC == 0) ? PTX_IDLE : PTX_GAP;
                    end else if (last_chunk) begin
                        ck_d = '0;
                        ch_d = ch_q + 1'b1;
                    end else begin
                        ck_d = ck_q + 1'b1;
                    end
                end
            end

            PTX_GAP: begin
                if (gap_q == GAP_W'(GAP_MAX)) begin
                    gap_d   = '0;
                    state_d = PTX_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = PTX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PTX_IDLE;
            ch_q      <= '0;
            ck_q      <= '0;
            frame_q   <= '0;
            snap_q    <= '0;
            refresh_q <= '0;
            gap_q     <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ck_q      <= ck_d;
            frame_q   <= frame_d;
            snap_q    <= snap_d;
            refresh_q <= refresh_d;
            gap_q     <= gap_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_uart   = wr_q;
    assign w_data    = data_q;
    assign busy      = (state_q != PTX_IDLE);
    assign frame_cnt = cnt_q;

endmodule
